// File: rtl/button_press_classifier.sv
// Classifies debounced button activity into short, long and double presses.
// Define BUTTON_PRESS_CLASSIFIER_DCLICK_EN to enable double-press detection.
module button_press_classifier #(
    parameter int CLK_FREQ_HZ = 10_000_000,
    parameter int LONG_MS     = 1000,
    parameter int DCLICK_MS   = 300,
    parameter int IS_PULLUP   = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_valid,
    input  logic btn_level,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic led,
    output logic busy
);
    localparam logic [31:0] LONG_CYC = 32'(CLK_FREQ_HZ / 1000 * LONG_MS);
    localparam logic [31:0] DCLK_CYC = 32'(CLK_FREQ_HZ / 1000 * DCLICK_MS);
    localparam logic        REL_LVL  = (IS_PULLUP != 0);

`ifdef BUTTON_PRESS_CLASSIFIER_DCLICK_EN
    typedef enum logic [2:0] {
        IDLE, PRESSED, LONG_HELD, WAIT_SECOND, SECOND_PRESSED
    } state_e;
    logic dbl_q, dbl_d;
`else
    typedef enum logic [1:0] {IDLE, PRESSED, LONG_HELD} state_e;
    logic unused_dclk;
    assign unused_dclk = ^DCLK_CYC;
`endif

    state_e      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic        short_q, short_d;
    logic        long_q, long_d;
    logic        led_q, led_d;
    logic        press_ev, rel_ev;

    assign press_ev = btn_valid && (btn_level != REL_LVL);
    assign rel_ev   = btn_valid && (btn_level == REL_LVL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            led_q   <= 1'b0;
`ifdef BUTTON_PRESS_CLASSIFIER_DCLICK_EN
            dbl_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            short_q <= short_d;
            long_q  <= long_d;
            led_q   <= led_d;
`ifdef BUTTON_PRESS_CLASSIFIER_DCLICK_EN
            dbl_q   <= dbl_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (press_ev) state_d = PRESSED;
            end
            PRESSED: begin
                timer_d = timer_q + 32'd1;
                // Release outranks the long-press timeout on the same cycle
                if (rel_ev) begin
                    timer_d = '0;
`ifdef BUTTON_PRESS_CLASSIFIER_DCLICK_EN
                    state_d = WAIT_SECOND;
`else
                    state_d = IDLE;
`endif
                end else if (timer_q == LONG_CYC - 32'd1) begin
                    state_d = LONG_HELD;
                end
            end
            LONG_HELD: begin
                if (rel_ev) state_d = IDLE;
            end
`ifdef BUTTON_PRESS_CLASSIFIER_DCLICK_EN
            WAIT_SECOND: begin
                timer_d = timer_q + 32'd1;
                if (press_ev) begin
                    state_d = SECOND_PRESSED;
                end else if (timer_q == DCLK_CYC - 32'd1) begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            end
            SECOND_PRESSED: begin
                if (rel_ev) state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_comb begin
        short_d = 1'b0;
        long_d  = 1'b0;
        if (state_q == PRESSED && !rel_ev && timer_q == LONG_CYC - 32'd1)
            long_d = 1'b1;
`ifdef BUTTON_PRESS_CLASSIFIER_DCLICK_EN
        dbl_d = 1'b0;
        if (state_q == WAIT_SECOND && !press_ev && timer_q == DCLK_CYC - 32'd1)
            short_d = 1'b1;
        if (state_q == SECOND_PRESSED && rel_ev)
            dbl_d = 1'b1;
`else
        if (state_q == PRESSED && rel_ev)
            short_d = 1'b1;
`endif
        led_d = led_q;
        unique case (1'b1)
            long_d:  led_d = 1'b0;
`ifdef BUTTON_PRESS_CLASSIFIER_DCLICK_EN
            dbl_d:   led_d = 1'b1;
`endif
            short_d: led_d = ~led_q;
            default: led_d = led_q;
        endcase
    end

    assign short_press = short_q;
    assign long_press  = long_q;
    assign led         = led_q;
    assign busy        = (state_q != IDLE);
`ifdef BUTTON_PRESS_CLASSIFIER_DCLICK_EN
    assign double_press = dbl_q;
`else
    assign double_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_press_classifier.sv
// Directed bench for button_press_classifier (LONG_CYC=1000, DCLK_CYC=300).
// Follows BUTTON_PRESS_CLASSIFIER_DCLICK_EN the same way the design does.
module tb_button_press_classifier;
`ifdef BUTTON_PRESS_CLASSIFIER_DCLICK_EN
    localparam int SLAT = 300;
`else
    localparam int SLAT = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_valid = 1'b0;
    logic btn_level = 1'b0;
    logic short_press, long_press, double_press, led, busy;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    int n_short = 0, n_long = 0, n_dbl = 0, n_multi = 0;
    int t_short = 0, t_long = 0, t_dbl = 0;
    int tp, tr, e_short, e_dbl;
    logic e_led;

    button_press_classifier #(
        .CLK_FREQ_HZ(10_000),
        .LONG_MS    (100),
        .DCLICK_MS  (30),
        .IS_PULLUP  (0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_valid   (btn_valid),
        .btn_level   (btn_level),
        .short_press (short_press),
        .long_press  (long_press),
        .double_press(double_press),
        .led         (led),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (short_press === 1'b1) begin
            n_short <= n_short + 1;
            t_short <= cyc;
        end
        if (long_press === 1'b1) begin
            n_long <= n_long + 1;
            t_long <= cyc;
        end
        if (double_press === 1'b1) begin
            n_dbl <= n_dbl + 1;
            t_dbl <= cyc;
        end
        if (int'(short_press) + int'(long_press) + int'(double_press) > 1)
            n_multi <= n_multi + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one event for exactly one edge; t is the cycle it was sampled
    task automatic ev(input logic lvl, output int t);
        btn_valid = 1'b1;
        btn_level = lvl;
        @(posedge clk);
        #1;
        t = cyc;
        btn_valid = 1'b0;
    endtask

    initial begin
        e_short = 0;
        e_dbl = 0;
        step(3);
        chk("rst_short", 32'(short_press), 0);
        chk("rst_long", 32'(long_press), 0);
        chk("rst_dbl", 32'(double_press), 0);
        chk("rst_led", 32'(led), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        step(2);

        // short click
        ev(1'b1, tp);
        chk("busy_press", 32'(busy), 1);
        step(200);
        ev(1'b0, tr);
`ifdef BUTTON_PRESS_CLASSIFIER_DCLICK_EN
        step(SLAT - 1);
        chk("short_early", 32'(n_short), 0);
        chk("busy_wait", 32'(busy), 1);
        step(2);
`else
        step(SLAT + 1);
`endif
        e_short = 1;
        e_led = 1'b1;
        chk("short_cnt", 32'(n_short), 32'(e_short));
        chk("short_lat", 32'(t_short - tr), 32'(SLAT));
        chk("short_led", 32'(led), 32'(e_led));
        chk("short_busy", 32'(busy), 0);

        // release while idle is ignored
        ev(1'b0, tr);
        step(2);
        chk("idle_rel_busy", 32'(busy), 0);
        chk("idle_rel_cnt", 32'(n_short), 32'(e_short));

        // long hold
        ev(1'b1, tp);
        step(1499);
        e_led = 1'b0;
        chk("long_cnt", 32'(n_long), 1);
        chk("long_lat", 32'(t_long - tp), 1000);
        chk("long_led", 32'(led), 32'(e_led));
        chk("long_busy", 32'(busy), 1);
        ev(1'b1, tr);
        step(1);
        chk("held_press_busy", 32'(busy), 1);
        ev(1'b0, tr);
        step(2);
        chk("held_rel_busy", 32'(busy), 0);
        chk("held_rel_long", 32'(n_long), 1);
        chk("held_rel_short", 32'(n_short), 32'(e_short));

        // release on the cycle the timer reaches LONG_CYC-1
        ev(1'b1, tp);
        step(999);
        ev(1'b0, tr);
        step(SLAT + 1);
        e_short++;
        e_led = ~e_led;
        chk("bnd_long", 32'(n_long), 1);
        chk("bnd_short", 32'(n_short), 32'(e_short));
        chk("bnd_lat", 32'(t_short - tr), 32'(SLAT));
        chk("bnd_led", 32'(led), 32'(e_led));

`ifdef BUTTON_PRESS_CLASSIFIER_DCLICK_EN
        // double press
        ev(1'b1, tp);
        step(100);
        ev(1'b0, tr);
        step(50);
        ev(1'b1, tp);
        step(100);
        ev(1'b0, tr);
        step(2);
        e_dbl = 1;
        e_led = 1'b1;
        chk("dbl_cnt", 32'(n_dbl), 32'(e_dbl));
        chk("dbl_lat", 32'(t_dbl - tr), 0);
        chk("dbl_led", 32'(led), 32'(e_led));
        step(400);
        chk("dbl_no_short", 32'(n_short), 32'(e_short));

        // second press on the dclick timeout cycle wins
        ev(1'b1, tp);
        step(10);
        ev(1'b0, tr);
        step(299);
        ev(1'b1, tp);
        step(10);
        ev(1'b0, tr);
        step(2);
        e_dbl = 2;
        chk("edge_dbl", 32'(n_dbl), 32'(e_dbl));
        chk("edge_short", 32'(n_short), 32'(e_short));
        chk("edge_led", 32'(led), 32'(e_led));
`else
        // quick clicks stay single presses
        for (int i = 0; i < 2; i++) begin
            ev(1'b1, tp);
            step(5);
            ev(1'b0, tr);
            step(1);
            e_short++;
            e_led = ~e_led;
            chk("quick_short", 32'(n_short), 32'(e_short));
            chk("quick_lat", 32'(t_short - tr), 0);
            chk("quick_led", 32'(led), 32'(e_led));
        end
        chk("quick_dbl", 32'(n_dbl), 0);
`endif

        // reset in the middle of a press
        chk("pre_rst_led", 32'(led), 1);
        ev(1'b1, tp);
        step(500);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_short", 32'(short_press), 0);
        chk("mid_rst_long", 32'(long_press), 0);
        chk("mid_rst_dbl", 32'(double_press), 0);
        chk("mid_rst_led", 32'(led), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        step(2);
        rst_n = 1'b1;
        step(1500);
        chk("post_rst_short", 32'(n_short), 32'(e_short));
        chk("post_rst_long", 32'(n_long), 1);
        chk("post_rst_dbl", 32'(n_dbl), 32'(e_dbl));
        chk("post_rst_busy", 32'(busy), 0);
        ev(1'b0, tr);
        step(2);
        chk("post_rst_rel", 32'(busy), 0);
        ev(1'b1, tp);
        step(20);
        ev(1'b0, tr);
        step(SLAT + 1);
        e_short++;
        chk("post_rst_click", 32'(n_short), 32'(e_short));
        chk("post_rst_led", 32'(led), 1);
        chk("onehot", 32'(n_multi), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/button_press_classifier.md
BUTTON_PRESS_CLASSIFIER -- requirements
Module: button_press_classifier

Interface
REQ-001 Parameter: CLK_FREQ_HZ, 10_000_000, system clock frequency in Hz.
REQ-002 Parameter: LONG_MS, 1000, hold time in ms for a long press.
REQ-003 Parameter: DCLICK_MS, 300, maximum gap in ms between release and second press for a double press.
REQ-004 Parameter: IS_PULLUP, 0, released button level (1 = released reads 1).
REQ-005 Port: clk, input, 1, system clock, rising-edge.
REQ-006 Port: rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 Port: btn_valid, input, 1, one-cycle pulse when the debounced level changes.
REQ-008 Port: btn_level, input, 1, debounced stable button level.
REQ-009 Port: short_press, output, 1, one-cycle pulse on a classified short press.
REQ-010 Port: long_press, output, 1, one-cycle pulse when the hold reaches LONG_MS.
REQ-011 Port: double_press, output, 1, one-cycle pulse on a classified double press.
REQ-012 Port: led, output, 1, registered LED state driven by the classified events.
REQ-013 Port: busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-014 Press event SHALL be btn_valid=1 with btn_level!=IS_PULLUP; release event SHALL be btn_valid=1 with btn_level==IS_PULLUP; cycles with btn_valid=0 SHALL carry no event.
REQ-015 LONG_CYC SHALL be CLK_FREQ_HZ/1000*LONG_MS and DCLK_CYC SHALL be CLK_FREQ_HZ/1000*DCLICK_MS, both computed at elaboration; the timer SHALL be 32 bits wide and unsigned.
REQ-016 FSM states SHALL be IDLE, PRESSED, LONG_HELD, WAIT_SECOND and SECOND_PRESSED.
REQ-017 IDLE: on a press event, go to PRESSED and clear the timer; ignore release events.
REQ-018 PRESSED: increment the timer every cycle; when the timer equals LONG_CYC-1, pulse long_press and go to LONG_HELD.
REQ-019 PRESSED: on a release event, go to WAIT_SECOND and clear the timer (behaviour without the macro is in REQ-030).
REQ-020 PRESSED: a release event and the LONG_CYC-1 timeout in the same cycle SHALL be treated as a release; long_press SHALL NOT pulse.
REQ-021 LONG_HELD: on a release event, go to IDLE with no pulse.
REQ-022 WAIT_SECOND: increment the timer; at DCLK_CYC-1, pulse short_press and go to IDLE; on a press event, go to SECOND_PRESSED; a press in the same cycle as the timeout SHALL win.
REQ-023 SECOND_PRESSED: on a release event, pulse double_press and go to IDLE; hold duration SHALL be ignored.
REQ-024 Event outputs SHALL be registered and assert exactly one cycle, on the clock edge after the triggering event or timeout; at most one event output SHALL be high in any cycle.
REQ-025 led SHALL toggle on short_press, clear on long_press and set on double_press, updating in the same cycle the pulse is registered.
REQ-026 A press event in a state that expects a release, or the reverse, SHALL be ignored with no state change.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, timer 0, short_press=long_press=double_press=0, led=0 and busy=0.
REQ-028 Reset asserted mid-classification SHALL discard the event in progress, with no pulse after reset release.
REQ-029 After reset release, the first event accepted SHALL be a press event.

Configuration
REQ-030 Macro BUTTON_PRESS_CLASSIFIER_DCLICK_EN: when defined, WAIT_SECOND and SECOND_PRESSED exist and double_press is functional; when undefined, a release in PRESSED SHALL pulse short_press and return to IDLE directly, WAIT_SECOND and SECOND_PRESSED SHALL be absent, and double_press SHALL be tied to 0.

Verification (CLK_FREQ_HZ=10_000, LONG_MS=100 -> LONG_CYC=1000, DCLICK_MS=30 -> DCLK_CYC=300, IS_PULLUP=0, macro defined unless noted)
REQ-031 Press, release 200 cycles later, no further events -> short_press pulses exactly 300 cycles after the release; led toggles 0->1; busy then drops.
REQ-032 Press held for 1500 cycles -> long_press pulses once, 1000 cycles after the press; led=0; release -> IDLE with no pulse.
REQ-033 Press 100 cycles, release, press again 50 cycles later, release 100 cycles after that -> a single double_press pulse and led=1; short_press never pulses.
REQ-034 Release event arriving on the cycle the timer reaches 999 -> no long_press; short_press follows after 300 cycles.
REQ-035 rst_n pulsed low 500 cycles into a press -> all outputs 0 immediately; no pulse afterwards until a new press is seen.
REQ-036 Macro undefined: press 100 cycles, then release -> short_press on the next cycle; a second quick click produces a second short_press and double_press stays 0.
